// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types.
// Line width, arbiter FSM states and transaction source tags.
package lc3b_types;

  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } arb_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } arb_src_t;

endpackage

// File: rtl/l2_arbiter.sv
// I/D-cache to unified L2 arbiter, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking (default: D wins).
module l2_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] l2_addr,
  output logic              l2_read,
  output logic              l2_write,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  arb_state_t        state_q;
  arb_state_t        state_nxt;
  arb_src_t          src_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] rbuf_q;

  logic i_req;
  logic d_req;
  logic tie_d;
  logic i_win;
  logic d_win;
  logic grant;
  logic busy;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  arb_src_t last_q;

  // Tie goes to whichever port lost the previous grant.
  assign tie_d = (last_q == SRC_I);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= SRC_I;
    end else if (state_q == IDLE && grant) begin
      last_q <= d_win ? SRC_D : SRC_I;
    end
  end
`else
  assign tie_d = 1'b1;
`endif

  always_comb begin
    d_win = 1'b0;
    i_win = 1'b0;
    unique case (1'b1)
      d_req && (!i_req || tie_d): d_win = 1'b1;
      i_req && !(d_req && tie_d): i_win = 1'b1;
      default: ;
    endcase
  end

  assign grant = d_win | i_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE: begin
        if (d_win)      state_nxt = BUSY_D;
        else if (i_win) state_nxt = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (l2_resp) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

  always_comb begin
    l2_read  = busy & ~wr_q;
    l2_write = busy & wr_q;
    i_resp   = (state_q == RESP) && (src_q == SRC_I);
    d_resp   = (state_q == RESP) && (src_q == SRC_D);
  end

  // Transaction registers; a write wins over a read on the D port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q   <= SRC_I;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == IDLE && grant) begin
      src_q  <= d_win ? SRC_D : SRC_I;
      wr_q   <= d_win & d_write;
      addr_q <= d_win ? d_addr : i_addr;
      if (d_win) wdata_q <= d_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbuf_q <= '0;
    end else if (busy && l2_resp) begin
      rbuf_q <= l2_rdata;
    end
  end

  assign l2_addr  = addr_q;
  assign l2_wdata = wdata_q;
  assign i_rdata  = rbuf_q;
  assign d_rdata  = rbuf_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed self-checking bench for l2_arbiter.
// Honours ARB_ROUND_ROBIN_EN when computing tie-break expectations.
module tb_l2_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] i_addr;
  logic          i_read;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic [AW-1:0] d_addr;
  logic          d_read;
  logic          d_write;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic [AW-1:0] l2_addr;
  logic          l2_read;
  logic          l2_write;
  logic [LW-1:0] l2_wdata;
  logic [LW-1:0] l2_rdata;
  logic          l2_resp;

  int checks;
  int failures;

  l2_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_addr   (i_addr),
    .i_read   (i_read),
    .i_rdata  (i_rdata),
    .i_resp   (i_resp),
    .d_addr   (d_addr),
    .d_read   (d_read),
    .d_write  (d_write),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_resp   (d_resp),
    .l2_addr  (l2_addr),
    .l2_read  (l2_read),
    .l2_write (l2_write),
    .l2_wdata (l2_wdata),
    .l2_rdata (l2_rdata),
    .l2_resp  (l2_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    i_addr = '0; i_read = 1'b0;
    d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    l2_rdata = '0; l2_resp = 1'b0;
    #22;
    checks++;
    if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b want=0000",
               {l2_read, l2_write, i_resp, d_resp});
    end
    checks++;
    if (l2_addr !== '0 || l2_wdata !== '0 ||
        i_rdata !== '0 || d_rdata !== '0) begin
      failures++;
      $display("FAIL reset_data addr=%h wdata=%h ird=%h drd=%h want 0",
               l2_addr, l2_wdata, i_rdata, d_rdata);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_tie;
    logic [AW-1:0] a2;
    logic [AW-1:0] a3;
    a2 = RR ? 16'h0040 : 16'h9000;
    a3 = RR ? 16'h9000 : 16'h0040;
    i_read = 1'b1; i_addr = 16'h0040;
    d_write = 1'b1; d_addr = 16'h8000; d_wdata = {8{16'hBEEF}};
    tick;
    checks++;
    if (l2_write !== 1'b1 || l2_read !== 1'b0 || l2_addr !== 16'h8000) begin
      failures++;
      $display("FAIL tie_first w=%b r=%b addr=%h want w=1 r=0 addr=8000",
               l2_write, l2_read, l2_addr);
    end
    checks++;
    if (l2_wdata !== {8{16'hBEEF}}) begin
      failures++;
      $display("FAIL tie_first_wdata got=%h want=%h",
               l2_wdata, {8{16'hBEEF}});
    end
    l2_resp = 1'b1;
    tick;
    l2_resp = 1'b0;
    checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
      failures++;
      $display("FAIL tie_first_resp d=%b i=%b want d=1 i=0", d_resp, i_resp);
    end
    d_addr = 16'h9000;
    tick;
    tick;
    checks++;
    if (l2_addr !== a2 || l2_write !== !RR || l2_read !== RR) begin
      failures++;
      $display("FAIL tie_second addr=%h w=%b r=%b want addr=%h w=%b r=%b",
               l2_addr, l2_write, l2_read, a2, !RR, RR);
    end
    l2_resp = 1'b1;
    tick;
    l2_resp = 1'b0;
    checks++;
    if (i_resp !== RR || d_resp !== !RR) begin
      failures++;
      $display("FAIL tie_second_resp i=%b d=%b want i=%b d=%b",
               i_resp, d_resp, RR, !RR);
    end
    if (RR) i_read = 1'b0;
    else    d_write = 1'b0;
    tick;
    tick;
    checks++;
    if (l2_addr !== a3 || l2_write !== RR || l2_read !== !RR) begin
      failures++;
      $display("FAIL tie_third addr=%h w=%b r=%b want addr=%h w=%b r=%b",
               l2_addr, l2_write, l2_read, a3, RR, !RR);
    end
    l2_resp = 1'b1;
    tick;
    l2_resp = 1'b0;
    checks++;
    if (i_resp !== !RR || d_resp !== RR) begin
      failures++;
      $display("FAIL tie_third_resp i=%b d=%b want i=%b d=%b",
               i_resp, d_resp, !RR, RR);
    end
    i_read = 1'b0; d_write = 1'b0;
    tick;
  endtask

  task automatic test_d_read;
    d_read = 1'b1; d_addr = 16'h1230;
    tick;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (l2_read !== 1'b1 || l2_write !== 1'b0 || l2_addr !== 16'h1230) begin
        failures++;
        $display("FAIL dread_busy c=%0d r=%b w=%b addr=%h want r=1 w=0 addr=1230",
                 c, l2_read, l2_write, l2_addr);
      end
      if (c == 3) begin
        l2_resp = 1'b1;
        l2_rdata = {16{8'hA5}};
      end
      tick;
    end
    l2_resp = 1'b0;
    l2_rdata = '0;
    checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || l2_read !== 1'b0) begin
      failures++;
      $display("FAIL dread_resp d=%b i=%b r=%b want d=1 i=0 r=0",
               d_resp, i_resp, l2_read);
    end
    checks++;
    if (d_rdata !== {16{8'hA5}}) begin
      failures++;
      $display("FAIL dread_rdata got=%h want=%h", d_rdata, {16{8'hA5}});
    end
    d_read = 1'b0;
    tick;
    checks++;
    if (d_resp !== 1'b0 || i_resp !== 1'b0 || l2_read !== 1'b0) begin
      failures++;
      $display("FAIL dread_after d=%b i=%b r=%b want 0 0 0",
               d_resp, i_resp, l2_read);
    end
  endtask

  task automatic test_idle_resp;
    l2_resp = 1'b1;
    tick;
    l2_resp = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({i_resp, d_resp, l2_read, l2_write} !== 4'b0) begin
        failures++;
        $display("FAIL idle_resp c=%0d got=%b want=0000",
                 c, {i_resp, d_resp, l2_read, l2_write});
      end
      tick;
    end
  endtask

  task automatic test_rw_both;
    d_read = 1'b1; d_write = 1'b1;
    d_addr = 16'h4000; d_wdata = {32{4'h1}};
    tick;
    checks++;
    if (l2_write !== 1'b1 || l2_read !== 1'b0) begin
      failures++;
      $display("FAIL rw_strobe w=%b r=%b want w=1 r=0", l2_write, l2_read);
    end
    checks++;
    if (l2_wdata !== {32{4'h1}} || l2_addr !== 16'h4000) begin
      failures++;
      $display("FAIL rw_data wdata=%h addr=%h want %h 4000",
               l2_wdata, l2_addr, {32{4'h1}});
    end
    l2_resp = 1'b1;
    l2_rdata = {4{32'h0BADF00D}};
    tick;
    l2_resp = 1'b0;
    checks++;
    if (d_resp !== 1'b1 || d_rdata !== {4{32'h0BADF00D}}) begin
      failures++;
      $display("FAIL rw_resp d=%b rdata=%h want 1 %h",
               d_resp, d_rdata, {4{32'h0BADF00D}});
    end
    d_read = 1'b0; d_write = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] addrs [4];
    addrs[0] = 16'h00A0; addrs[1] = 16'h00B0;
    addrs[2] = 16'h00C0; addrs[3] = 16'h00D0;
    i_addr = addrs[0]; i_read = 1'b1;
    tick;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (l2_read !== 1'b1 || l2_addr !== addrs[n] || i_resp !== 1'b0) begin
        failures++;
        $display("FAIL b2b_busy n=%0d r=%b addr=%h resp=%b want 1 %h 0",
                 n, l2_read, l2_addr, i_resp, addrs[n]);
      end
      i_addr = addrs[n+1];
      l2_resp = 1'b1;
      l2_rdata = LW'(n + 7);
      tick;
      l2_resp = 1'b0;
      checks++;
      if (i_resp !== 1'b1 || l2_addr !== addrs[n] ||
          i_rdata !== LW'(n + 7)) begin
        failures++;
        $display("FAIL b2b_resp n=%0d resp=%b addr=%h rdata=%h want 1 %h %0d",
                 n, i_resp, l2_addr, i_rdata, addrs[n], n + 7);
      end
      if (n == 2) i_read = 1'b0;
      tick;
      checks++;
      if (i_resp !== 1'b0 || l2_read !== 1'b0) begin
        failures++;
        $display("FAIL b2b_idle n=%0d resp=%b r=%b want 0 0",
                 n, i_resp, l2_read);
      end
      tick;
    end
    checks++;
    if (l2_read !== 1'b0 || i_resp !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end r=%b resp=%b want 0 0", l2_read, i_resp);
    end
  endtask

  task automatic test_addr_hold;
    d_read = 1'b1; d_addr = 16'h2000;
    tick;
    d_addr = 16'h3000;
    tick;
    checks++;
    if (l2_addr !== 16'h2000 || l2_read !== 1'b1) begin
      failures++;
      $display("FAIL hold_busy addr=%h r=%b want 2000 1", l2_addr, l2_read);
    end
    l2_resp = 1'b1;
    tick;
    l2_resp = 1'b0;
    checks++;
    if (l2_addr !== 16'h2000 || d_resp !== 1'b1) begin
      failures++;
      $display("FAIL hold_resp addr=%h resp=%b want 2000 1", l2_addr, d_resp);
    end
    tick;
    tick;
    checks++;
    if (l2_addr !== 16'h3000 || l2_read !== 1'b1) begin
      failures++;
      $display("FAIL hold_next addr=%h r=%b want 3000 1", l2_addr, l2_read);
    end
    d_read = 1'b0;
    l2_resp = 1'b1;
    tick;
    l2_resp = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    i_read = 1'b1; i_addr = 16'h0ABC;
    tick;
    checks++;
    if (l2_read !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy r=%b want 1", l2_read);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (l2_read !== 1'b0 || l2_addr !== '0) begin
      failures++;
      $display("FAIL mid_async r=%b addr=%h want 0 0000", l2_read, l2_addr);
    end
    i_read = 1'b0;
    l2_resp = 1'b1;
    #10;
    l2_resp = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++;
      if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0 ||
          l2_addr !== '0 || l2_wdata !== '0 ||
          i_rdata !== '0 || d_rdata !== '0) begin
        failures++;
        $display("FAIL mid_after c=%0d strobes=%b addr=%h rdata=%h want 0",
                 c, {l2_read, l2_write, i_resp, d_resp}, l2_addr, i_rdata);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_tie;
    test_d_read;
    test_idle_resp;
    test_rw_both;
    test_back_to_back;
    test_addr_hold;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
